// File: rtl/sram_dp_param.sv
// rtl/sram_dp_param.sv - parametrised true dual-port SRAM model with bit masks and clear sequencer
// Both ports share one clock; a clear sequencer zeroes the array after reset or on request.
module sram_dp_param #(
   parameter int WIDTH      = 18,
   parameter int DEPTH      = 1024,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int WRITE_MODE = 0,
   parameter int OUT_REG    = 0,
   parameter int INIT_CLEAR = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              busy,
   input  logic              cen_a,
   input  logic              wen_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [WIDTH-1:0]  wmsk_a,
   input  logic [WIDTH-1:0]  wdata_a,
   output logic [WIDTH-1:0]  rdata_a,
   input  logic              cen_b,
   input  logic              wen_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [WIDTH-1:0]  wmsk_b,
   input  logic [WIDTH-1:0]  wdata_b,
   output logic [WIDTH-1:0]  rdata_b
);

   typedef enum logic {ST_READY, ST_CLEAR} state_t;

   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;

   logic             acc_a, acc_b, inr_a, inr_b, wr_a, wr_b, coll_w;
   logic [WIDTH-1:0] old_a, old_b, merge_a, merge_b, both_w, new_a, new_b;
   logic [WIDTH-1:0] rd_a, rd_b;
   logic [WIDTH-1:0] rd1_a_q, rd1_a_d, rd1_b_q, rd1_b_d;
   logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic             vld_a_q, vld_a_d, vld_b_q, vld_b_d;

   // A busy array behaves as if both ports were deselected
   always_comb begin
      acc_a   = !cen_a && !busy_q;
      acc_b   = !cen_b && !busy_q;
      inr_a   = {1'b0, addr_a} < DEPTH_L;
      inr_b   = {1'b0, addr_b} < DEPTH_L;
      old_a   = inr_a ? mem[addr_a] : '0;
      old_b   = inr_b ? mem[addr_b] : '0;
      wr_a    = acc_a && !wen_a && inr_a;
      wr_b    = acc_b && !wen_b && inr_b;
      coll_w  = wr_a && wr_b && (addr_a == addr_b);
      merge_a = (old_a & wmsk_a) | (wdata_a & ~wmsk_a);
      merge_b = (old_b & wmsk_b) | (wdata_b & ~wmsk_b);
      // Port A owns every bit it unmasks; port B fills the bits A leaves alone
      both_w  = (old_a & wmsk_a & wmsk_b) | (wdata_b & ~wmsk_b & wmsk_a) | (wdata_a & ~wmsk_a);
      new_a   = coll_w ? both_w : merge_a;
      new_b   = coll_w ? both_w : merge_b;
      rd_a    = (wr_a && (WRITE_MODE != 0)) ? new_a : old_a;
      rd_b    = (wr_b && (WRITE_MODE != 0)) ? new_b : old_b;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (busy_q) begin
            mem[cnt_q] <= '0;
         end else begin
            if (wr_b && !coll_w) mem[addr_b] <= merge_b;
            if (wr_a)            mem[addr_a] <= new_a;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      if (state_q == ST_READY) begin
         if (clr_req) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            busy_d  = 1'b1;
         end
      end else begin
         if (cnt_q == LAST_ADR) begin
            state_d = ST_READY;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // The second stage reloads one cycle after any access, even if the port is idle by then
   always_comb begin
      rd1_a_d = acc_a ? rd_a : rd1_a_q;
      rd1_b_d = acc_b ? rd_b : rd1_b_q;
      vld_a_d = acc_a;
      vld_b_d = acc_b;
      out_a_d = vld_a_q ? rd1_a_q : out_a_q;
      out_b_d = vld_b_q ? rd1_b_q : out_b_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
         cnt_q   <= '0;
         busy_q  <= (INIT_CLEAR != 0);
         rd1_a_q <= '0;
         rd1_b_q <= '0;
         vld_a_q <= 1'b0;
         vld_b_q <= 1'b0;
         out_a_q <= '0;
         out_b_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         rd1_a_q <= rd1_a_d;
         rd1_b_q <= rd1_b_d;
         vld_a_q <= vld_a_d;
         vld_b_q <= vld_b_d;
         out_a_q <= out_a_d;
         out_b_q <= out_b_d;
      end
   end

   assign busy    = busy_q;
   assign rdata_a = (OUT_REG != 0) ? out_a_q : rd1_a_q;
   assign rdata_b = (OUT_REG != 0) ? out_b_q : rd1_b_q;

endmodule

// File: tb/tb_sram_dp_param.sv
// tb/tb_sram_dp_param.sv - scoreboard bench for sram_dp_param in two configurations
// dut0: defaults; dut1: DEPTH=16, write-first, output register.
module tb_sram_dp_param;

   typedef struct {
      int          due;
      int          sel;
      logic [17:0] exp;
      string       name;
   } sb_t;

   logic clk = 1'b0;
   logic rst0_n, rst1_n, clr0, clr1, busy0, busy1;
   logic ca0, wa0, cb0, wb0, ca1, wa1, cb1, wb1;
   logic [9:0]  aa0, ab0;
   logic [3:0]  aa1, ab1;
   logic [17:0] ma0, da0, mb0, db0, ra0, rb0, ma1, da1, mb1, db1, ra1, rb1;

   int  cyc = 0;
   int  n_chk = 0;
   int  n_err = 0;
   int  n_busy;
   sb_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_dp_param dut0 (
      .clk(clk), .rst_n(rst0_n), .clr_req(clr0), .busy(busy0),
      .cen_a(ca0), .wen_a(wa0), .addr_a(aa0), .wmsk_a(ma0), .wdata_a(da0), .rdata_a(ra0),
      .cen_b(cb0), .wen_b(wb0), .addr_b(ab0), .wmsk_b(mb0), .wdata_b(db0), .rdata_b(rb0)
   );

   sram_dp_param #(.WIDTH(18), .DEPTH(16), .WRITE_MODE(1), .OUT_REG(1), .INIT_CLEAR(1)) dut1 (
      .clk(clk), .rst_n(rst1_n), .clr_req(clr1), .busy(busy1),
      .cen_a(ca1), .wen_a(wa1), .addr_a(aa1), .wmsk_a(ma1), .wdata_a(da1), .rdata_a(ra1),
      .cen_b(cb1), .wen_b(wb1), .addr_b(ab1), .wmsk_b(mb1), .wdata_b(db1), .rdata_b(rb1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [17:0] rd_sel(input int sel);
      case (sel)
         0:       return ra0;
         1:       return rb0;
         2:       return ra1;
         default: return rb1;
      endcase
   endfunction

   function automatic logic busy_of(input int sel);
      return (sel == 0) ? busy0 : busy1;
   endfunction

   // sel 0/1 = dut0 port A/B (latency 1), sel 2/3 = dut1 port A/B (latency 2)
   task automatic expect_rd(input int sel, input logic [17:0] val, input string name);
      sb_t e;
      e.due  = cyc + 1 + ((sel >= 2) ? 1 : 0);
      e.sel  = sel;
      e.exp  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic idle();
      ca0 = 1'b1; wa0 = 1'b1; cb0 = 1'b1; wb0 = 1'b1;
      ca1 = 1'b1; wa1 = 1'b1; cb1 = 1'b1; wb1 = 1'b1;
      clr0 = 1'b0; clr1 = 1'b0;
   endtask

   task automatic acc(input int sel, input bit wr, input int addr,
                      input logic [17:0] msk, input logic [17:0] dat);
      case (sel)
         0: begin ca0 = 1'b0; wa0 = !wr; aa0 = addr[9:0]; ma0 = msk; da0 = dat; end
         1: begin cb0 = 1'b0; wb0 = !wr; ab0 = addr[9:0]; mb0 = msk; db0 = dat; end
         2: begin ca1 = 1'b0; wa1 = !wr; aa1 = addr[3:0]; ma1 = msk; da1 = dat; end
         default: begin cb1 = 1'b0; wb1 = !wr; ab1 = addr[3:0]; mb1 = msk; db1 = dat; end
      endcase
   endtask

   // Counts negedge samples with busy high; dut1 is hammered with writes while busy,
   // dut0 gets a second clr_req (plus a read) at iteration pulse_at
   task automatic count_busy(input int sel, input int pulse_at, output int n);
      n = 0;
      while (busy_of(sel) && n < 5000) begin
         idle();
         if (sel == 1) acc(2, 1'b1, 3, 18'h00000, 18'h3FFFF);
         if (n == pulse_at) begin
            clr0 = 1'b1;
            acc(0, 1'b0, 10'h3FF, 18'h0, 18'h0);
         end
         n++;
         @(negedge clk);
      end
      idle();
   endtask

   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].due == cyc) begin
            check(sb[i].name, {14'h0, rd_sel(sb[i].sel)}, {14'h0, sb[i].exp});
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst0_n = 1'b0; rst1_n = 1'b0;
      aa0 = '0; ab0 = '0; aa1 = '0; ab1 = '0;
      ma0 = '0; da0 = '0; mb0 = '0; db0 = '0; ma1 = '0; da1 = '0; mb1 = '0; db1 = '0;
      idle();
      repeat (3) @(negedge clk);
      check("rst_ra0", ra0, 0);
      check("rst_rb0", rb0, 0);
      check("rst_ra1", ra1, 0);
      check("rst_rb1", rb1, 0);
      check("rst_busy0", busy0, 1);
      check("rst_busy1", busy1, 1);

      // dut1: abort the clear after 8 addresses, then it must restart from scratch
      rst1_n = 1'b1;
      repeat (8) @(negedge clk);
      rst1_n = 1'b0;
      #1;
      check("midclr_busy", busy1, 1);
      check("midclr_ra1", ra1, 0);
      @(negedge clk);
      rst1_n = 1'b1;
      count_busy(1, -1, n_busy);
      check("midclr_busy_cycles", n_busy, 16);
      check("midclr_hold", ra1, 0);
      for (int i = 0; i < 16; i++) begin
         idle();
         acc(2, 1'b0, i, 18'h0, 18'h0);
         acc(3, 1'b0, 15 - i, 18'h0, 18'h0);
         expect_rd(2, 18'h00000, $sformatf("clr1_a_%0d", i));
         expect_rd(3, 18'h00000, $sformatf("clr1_b_%0d", 15 - i));
         @(negedge clk);
      end
      idle();

      // dut0: power-on clear of 1024 words
      rst0_n = 1'b1;
      count_busy(0, -1, n_busy);
      check("init_busy_cycles", n_busy, 1024);

      idle(); acc(0, 1'b0, 10'h3FF, 18'h0, 18'h0);
      expect_rd(0, 18'h00000, "clr_last");
      @(negedge clk);
      idle(); acc(0, 1'b1, 5, 18'h00000, 18'h3FFFF);
      expect_rd(0, 18'h00000, "mw1_old");
      @(negedge clk);
      idle(); acc(0, 1'b1, 5, 18'h3FF00, 18'h00000);
      expect_rd(0, 18'h3FFFF, "mw2_old");
      @(negedge clk);
      idle(); acc(0, 1'b0, 5, 18'h0, 18'h0);
      expect_rd(0, 18'h3FF00, "mask_rd");
      @(negedge clk);
      idle();
      acc(0, 1'b1, 7, 18'h0, 18'h12345);
      acc(2, 1'b1, 7, 18'h0, 18'h12345);
      expect_rd(0, 18'h00000, "ld7_wm0");
      expect_rd(2, 18'h12345, "ld7_wm1");
      @(negedge clk);
      idle();
      acc(1, 1'b1, 7, 18'h0, 18'h0ABCD);
      acc(3, 1'b1, 7, 18'h0, 18'h0ABCD);
      expect_rd(1, 18'h12345, "rdw_wm0");
      expect_rd(3, 18'h0ABCD, "rdw_wm1");
      @(negedge clk);
      idle();
      acc(0, 1'b0, 7, 18'h0, 18'h0);
      acc(2, 1'b0, 7, 18'h0, 18'h0);
      expect_rd(0, 18'h0ABCD, "rd7_wm0");
      expect_rd(2, 18'h0ABCD, "rd7_wm1");
      @(negedge clk);
      idle();
      acc(0, 1'b1, 9, 18'h0FFFF, 18'h3FFFF);
      acc(1, 1'b1, 9, 18'h00000, 18'h15555);
      expect_rd(0, 18'h00000, "coll_ra");
      expect_rd(1, 18'h00000, "coll_rb");
      @(negedge clk);
      idle(); acc(0, 1'b0, 9, 18'h0, 18'h0);
      expect_rd(0, 18'h35555, "coll_merge");
      @(negedge clk);
      idle();
      acc(0, 1'b0, 9, 18'h0, 18'h0);
      acc(1, 1'b1, 9, 18'h0, 18'h00001);
      acc(2, 1'b0, 7, 18'h0, 18'h0);
      acc(3, 1'b1, 7, 18'h0, 18'h00111);
      expect_rd(0, 18'h35555, "rw_coll_rd0");
      expect_rd(1, 18'h35555, "rw_coll_wr0");
      expect_rd(2, 18'h0ABCD, "rw_coll_rd1");
      expect_rd(3, 18'h00111, "rw_coll_wr1");
      @(negedge clk);
      idle();
      acc(0, 1'b0, 9, 18'h0, 18'h0);
      acc(1, 1'b0, 9, 18'h0, 18'h0);
      acc(2, 1'b0, 7, 18'h0, 18'h0);
      acc(3, 1'b0, 7, 18'h0, 18'h0);
      expect_rd(0, 18'h00001, "rr_a0");
      expect_rd(1, 18'h00001, "rr_b0");
      expect_rd(2, 18'h00111, "rr_a1");
      expect_rd(3, 18'h00111, "rr_b1");
      @(negedge clk);

      // Output register: result appears after the second edge, then holds
      idle(); acc(3, 1'b1, 2, 18'h0, 18'h00042);
      expect_rd(3, 18'h00042, "ld2_wm1");
      @(negedge clk);
      idle(); acc(2, 1'b0, 2, 18'h0, 18'h0);
      expect_rd(2, 18'h00042, "oreg_rd");
      @(negedge clk);
      idle();
      check("oreg_first_edge", ra1, 18'h00111);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("oreg_hold_%0d", i), ra1, 18'h00042);
      end
      check("hold_a0", ra0, 18'h00001);

      // Runtime clear with an access on the request edge and a second ignored request
      idle(); clr0 = 1'b1; acc(0, 1'b0, 9, 18'h0, 18'h0);
      expect_rd(0, 18'h00001, "clr_edge_rd");
      @(negedge clk);
      idle();
      count_busy(0, 500, n_busy);
      check("rt_busy_cycles", n_busy, 1024);
      check("rt_busy_hold", ra0, 18'h00001);
      acc(0, 1'b0, 9, 18'h0, 18'h0);
      acc(1, 1'b0, 10'h3FF, 18'h0, 18'h0);
      expect_rd(0, 18'h00000, "rt_clr_9");
      expect_rd(1, 18'h00000, "rt_clr_3ff");
      @(negedge clk);
      idle();

      repeat (4) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sram_dp_param.md
Name: sram_dp_param

Overview:
- Parametrised true dual-port SRAM behavioural model; successor to the fixed 1024x18 macro model.
- Generalises width and depth, with per-port active-low chip enable, write enable and bit mask.
- Adds a read-during-write mode, an optional output register, deterministic cross-port collision rules, and a hardware clear sequencer with a busy flag.
- Used as the simulation/synthesis model behind the BRAM inference maps of the qlf_k6n10f flow.

Parameters:
- WIDTH, 18, data/mask width in bits (1..64)
- DEPTH, 1024, number of words (2..4096, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width; derived, do not override
- WRITE_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (merged new data)
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- INIT_CLEAR, 1, 1 = zero the whole array automatically after reset release; 0 = array starts X, block is ready at once

Ports:
- clk  in  1  single clock for both ports, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr_req  in  1  pulse high for one cycle to start a runtime clear of the array
- busy  out  1  high while the clear sequencer runs
- cen_a  in  1  port A chip enable, active low
- wen_a  in  1  port A write enable, active low; meaningful only when cen_a=0
- addr_a  in  ADDR_W  port A word address
- wmsk_a  in  WIDTH  port A bit mask; 1 = keep old bit, 0 = write wdata bit
- wdata_a  in  WIDTH  port A write data
- rdata_a  out  WIDTH  port A read data
- cen_b, wen_b, addr_b, wmsk_b, wdata_b, rdata_b: same as port A, for port B

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0: rdata_a=0, rdata_b=0, and the OUT_REG stage (if present) is 0.
  - busy=INIT_CLEAR; the clear counter is 0; memory contents are not reset.
- Access cycle (busy=0): the port controls are sampled at rising edge N.
  - Enabled access: cen=0.
  - Write: cen=0 and wen=0. For each bit i, mem[addr][i] becomes wmsk[i] ? old bit : wdata[i], committed at edge N.
  - Read: any enabled access, write or not, returns data.
    - OUT_REG=0: rdata is valid after edge N.
    - OUT_REG=1: rdata is valid after edge N+1.
  - Same-port write: rdata follows WRITE_MODE — pre-write word for 0, post-merge word for 1.
  - cen=1: no access, and rdata holds its last value indefinitely (with OUT_REG=1, the output stage also holds).
  - Addresses >= DEPTH: writes are discarded and reads return 0.
- Cross-port collision, same address at the same edge:
  - Both ports writing: per bit, a port-A write (A cen=0, wen=0, wmsk=0) takes that bit; otherwise a port-B write takes it; otherwise the old bit is kept.
  - One port reads while the other writes: the reader gets the pre-write word, regardless of WRITE_MODE.
  - Both ports reading: both get the same word.
- Clear FSM, states READY and CLEAR:
  - After reset release: enter CLEAR if INIT_CLEAR=1, else READY.
  - READY -> CLEAR on clr_req=1 sampled at an edge; busy rises after that edge.
  - CLEAR writes 0 to mem[cnt] each cycle, with cnt running 0..DEPTH-1.
  - CLEAR -> READY at the edge that writes DEPTH-1; busy=0 after that edge. Total clear takes DEPTH cycles.
  - While busy=1: port accesses are ignored (treated as cen=1) and rdata holds.
  - clr_req while busy=1 is ignored; it does not restart the clear.
  - Reset asserted mid-clear aborts the clear. After release, the sequence restarts at address 0 if INIT_CLEAR=1; otherwise the block returns to READY with a partially cleared array.
  - A port access arriving on the clr_req edge is performed, because busy was still 0 at that edge.
- Width rules: mask and data are exactly WIDTH bits with no sign extension; ADDR_W comes from $clog2(DEPTH).

Test Plan:
- Reset then clear: defaults, release rst_n, count busy-high cycles -> busy stays high for exactly 1024 cycles; then a port A read of addr 0x3FF returns 0x00000 one edge later.
- Masked write: port A writes 0x3FFFF at addr 5, then writes wdata 0x00000 with wmsk 0x3FF00, then reads addr 5 -> rdata_a = 0x3FF00.
- Read-during-write, both WRITE_MODE values, with addr 7 first loaded to 0x12345: port B writes 0x0ABCD to addr 7 while reading it -> WRITE_MODE=0 returns 0x12345; WRITE_MODE=1 returns 0x0ABCD.
- Cross-port collision, old word 0x00000: same edge, A writes 0x3FFFF with wmsk 0x0FFFF and B writes 0x15555 with wmsk 0x00000, both at addr 9 -> mem[9] = 0x35555 (bits 17:16 from A, 15:0 from B).
- Hold and OUT_REG: with OUT_REG=1, read addr 2 (holding 0x00042), then set cen_a=1 for 10 cycles -> rdata_a becomes 0x00042 after the second edge and stays stable.
- Reset mid-clear: DEPTH=16, assert rst_n low at clear cycle 8, release -> busy high for 16 full cycles; reads are ignored while busy; every address reads 0 afterwards.
